branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 133 +++++++++++++
 tb/tb_branch_target_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating predictors and a
// two-stage (decode, ALU) pipeline carrying the fetch-time hit/prediction.
module branch_target_buffer #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_fetch,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_alu,
    input  logic [31:0] target_alu,
    input  logic        result_alu,
    input  logic        write_rp,
    input  logic        write_rt,
    output logic        hit_fetch,
    output logic        p_fetch,
    output logic [31:0] target_fetch,
    output logic        hit_alu,
    output logic        p_alu
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];
    logic [1:0]          cnt_d    [ENTRIES];

    logic dec_hit_q, dec_hit_d, dec_p_q, dec_p_d;
    logic alu_hit_q, alu_hit_d, alu_p_q, alu_p_d;

    logic [INDEX_BITS-1:0] fetch_idx, alu_idx;
    logic [TAG_BITS-1:0]   fetch_tag, alu_tag;
    logic                  alu_match;
    logic                  unused_pc_lsbs;

    assign fetch_idx      = pc_fetch[INDEX_BITS+1:2];
    assign fetch_tag      = pc_fetch[31:INDEX_BITS+2];
    assign alu_idx        = pc_alu[INDEX_BITS+1:2];
    assign alu_tag        = pc_alu[31:INDEX_BITS+2];
    assign unused_pc_lsbs = ^{pc_fetch[1:0], pc_alu[1:0]};

    function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? 2'b11 : c + 2'b01;
        end
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Lookup reads the registered table, so same-cycle writes are not visible.
    always_comb begin
        hit_fetch    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        p_fetch      = hit_fetch & cnt_q[fetch_idx][1];
        target_fetch = hit_fetch ? target_q[fetch_idx] : 32'h0;
    end

    assign alu_match = valid_q[alu_idx] && (tag_q[alu_idx] == alu_tag);

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            cnt_d[i]    = cnt_q[i];
        end
        if (write_rt) begin
            valid_d[alu_idx]  = 1'b1;
            tag_d[alu_idx]    = alu_tag;
            target_d[alu_idx] = target_alu;
            cnt_d[alu_idx]    = result_alu ? 2'b10 : 2'b01;
        end else if (write_rp && alu_match) begin
            cnt_d[alu_idx] = sat_cnt(cnt_q[alu_idx], result_alu);
        end
    end

    always_comb begin
        dec_hit_d = dec_hit_q;
        dec_p_d   = dec_p_q;
        alu_hit_d = alu_hit_q;
        alu_p_d   = alu_p_q;
        if (flush) begin
            dec_hit_d = 1'b0;
            dec_p_d   = 1'b0;
            alu_hit_d = 1'b0;
            alu_p_d   = 1'b0;
        end else if (!stall) begin
            dec_hit_d = hit_fetch;
            dec_p_d   = p_fetch;
            alu_hit_d = dec_hit_q;
            alu_p_d   = dec_p_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b01;
            end
            dec_hit_q <= 1'b0;
            dec_p_q   <= 1'b0;
            alu_hit_q <= 1'b0;
            alu_p_q   <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= valid_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            dec_hit_q <= dec_hit_d;
            dec_p_q   <= dec_p_d;
            alu_hit_q <= alu_hit_d;
            alu_p_q   <= alu_p_d;
        end
    end

    // Tag/target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
        end
    end

    assign hit_alu = alu_hit_q;
    assign p_alu   = alu_p_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: a behavioural table model
// queues expected outputs per cycle, which are popped against the DUT.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_fetch, pc_alu, target_alu;
    logic        stall, flush, result_alu, write_rp, write_rt;
    logic        hit_fetch, p_fetch, hit_alu, p_alu;
    logic [31:0] target_fetch;

    branch_target_buffer #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .pc_fetch(pc_fetch), .stall(stall), .flush(flush),
        .pc_alu(pc_alu), .target_alu(target_alu), .result_alu(result_alu),
        .write_rp(write_rp), .write_rt(write_rt), .hit_fetch(hit_fetch),
        .p_fetch(p_fetch), .target_fetch(target_fetch), .hit_alu(hit_alu), .p_alu(p_alu)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    // Reference model state
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_target[16];
    logic [1:0]  m_cnt   [16];
    logic        m_dec_hit, m_dec_p, m_alu_hit, m_alu_p;
    logic        e_hit, e_p;
    logic [31:0] e_tgt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 2'b01;
            m_tag[i]   = '0;
            m_target[i] = '0;
        end
        m_dec_hit = 0; m_dec_p = 0; m_alu_hit = 0; m_alu_p = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc);
        int idx;
        idx   = int'(pc[5:2]);
        e_hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        e_p   = e_hit && (m_cnt[idx] >= 2'b10);
        e_tgt = e_hit ? m_target[idx] : 32'h0;
    endtask

    task automatic push_expected(input string tag);
        name_q.push_back({tag, ".hit_fetch"});    exp_q.push_back({31'b0, e_hit});
        name_q.push_back({tag, ".p_fetch"});      exp_q.push_back({31'b0, e_p});
        name_q.push_back({tag, ".target_fetch"}); exp_q.push_back(e_tgt);
        name_q.push_back({tag, ".hit_alu"});      exp_q.push_back({31'b0, m_alu_hit});
        name_q.push_back({tag, ".p_alu"});        exp_q.push_back({31'b0, m_alu_p});
    endtask

    task automatic compare_outputs();
        logic [31:0] got[5];
        got[0] = {31'b0, hit_fetch};
        got[1] = {31'b0, p_fetch};
        got[2] = target_fetch;
        got[3] = {31'b0, hit_alu};
        got[4] = {31'b0, p_alu};
        for (int k = 0; k < 5; k++) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'h1, 32'h0);
            end else begin
                check(name_q.pop_front(), got[k], exp_q.pop_front());
            end
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, then advance the model.
    task automatic cycle(input string tag, input logic [31:0] pcf,
                         input logic st, input logic fl,
                         input logic [31:0] pca, input logic [31:0] tga,
                         input logic res, input logic wrp, input logic wrt);
        int ai;
        logic f_hit, f_p, a_match;
        @(negedge clk);
        pc_fetch = pcf; stall = st; flush = fl; pc_alu = pca; target_alu = tga;
        result_alu = res; write_rp = wrp; write_rt = wrt;
        model_lookup(pcf);
        f_hit = e_hit; f_p = e_p;
        push_expected(tag);
        #1;
        compare_outputs();
        @(posedge clk);
        if (fl) begin
            m_dec_hit = 0; m_dec_p = 0; m_alu_hit = 0; m_alu_p = 0;
        end else if (!st) begin
            m_alu_hit = m_dec_hit; m_alu_p = m_dec_p;
            m_dec_hit = f_hit;     m_dec_p = f_p;
        end
        ai = int'(pca[5:2]);
        a_match = m_valid[ai] && (m_tag[ai] == pca[31:6]);
        if (wrt) begin
            m_valid[ai] = 1'b1; m_tag[ai] = pca[31:6]; m_target[ai] = tga;
            m_cnt[ai] = res ? 2'b10 : 2'b01;
        end else if (wrp && a_match) begin
            if (res) m_cnt[ai] = (m_cnt[ai] == 2'b11) ? 2'b11 : m_cnt[ai] + 2'b01;
            else     m_cnt[ai] = (m_cnt[ai] == 2'b00) ? 2'b00 : m_cnt[ai] - 2'b01;
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pcf);
        cycle(tag, pcf, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; pc_fetch = 32'h40; stall = 0; flush = 0; pc_alu = 0;
        target_alu = 0; result_alu = 0; write_rp = 0; write_rt = 0;
        model_reset();
        #2;
        push_expected("in_reset");
        compare_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        look("after_reset", 32'h40);
        // Allocate 0x40 taken; same-cycle lookup must still miss
        cycle("alloc40", 32'h40, 0, 0, 32'h40, 32'h100, 1'b1, 1'b0, 1'b1);
        look("hit40", 32'h40);
        look("pipe1", 32'h0);
        look("pipe2", 32'h0);
        // Counter walks down, saturates at 00, then up to 11
        for (int i = 0; i < 3; i++)
            cycle("dec40", 32'h40, 0, 0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle("inc40", 32'h40, 0, 0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle("down_from_sat", 32'h40, 0, 0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
        look("after_down", 32'h40);
        // rt and rp together: rt wins, counter reinitialised to 01
        cycle("rt_rp_both", 32'h40, 0, 0, 32'h40, 32'h104, 1'b0, 1'b1, 1'b1);
        look("after_both", 32'h40);
        // rp with tag mismatch or on an invalid entry is ignored
        cycle("rp_mismatch", 32'h40, 0, 0, 32'hC0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle("rp_invalid", 32'h44, 0, 0, 32'h44, 32'h0, 1'b1, 1'b1, 1'b0);
        look("chk40", 32'h40);
        look("chk44", 32'h44);
        // Aliasing at index 0
        look("alias80", 32'h80);
        cycle("alloc80", 32'h80, 0, 0, 32'h80, 32'h200, 1'b0, 1'b0, 1'b1);
        look("evicted40", 32'h40);
        look("hit80", 32'h80);
        // Stall holds, flush overrides stall
        cycle("alloc44", 32'h0, 0, 0, 32'h44, 32'h300, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) look("fill44", 32'h44);
        for (int i = 0; i < 3; i++)
            cycle("stall", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle("flush_stall", 32'h44, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("after_flush", 32'h44);
        look("after_flush2", 32'hFFFF_FFC4);
        // Table writes proceed during stall
        cycle("wr_in_stall", 32'h0, 1'b1, 1'b0, 32'h48, 32'h400, 1'b1, 1'b0, 1'b1);
        look("hit48", 32'h48);
        // Mid-run reset with a pending write discards everything
        @(negedge clk);
        pc_fetch = 32'h44; pc_alu = 32'h4C; target_alu = 32'h500;
        result_alu = 1'b1; write_rt = 1'b1; write_rp = 1'b0; stall = 0; flush = 0;
        rst = 1'b1;
        model_reset();
        #1;
        e_hit = 0; e_p = 0; e_tgt = 0;
        push_expected("mid_reset");
        compare_outputs();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        write_rt = 1'b0;
        look("post_rst44", 32'h44);
        look("post_rst4c", 32'h4C);
        look("post_rst80", 32'h80);
        cycle("first_write", 32'h0, 0, 0, 32'h40, 32'h600, 1'b1, 1'b0, 1'b1);
        look("hit40_again", 32'h40);
        look("drain1", 32'h0);
        look("drain2", 32'h0);

        if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
